// File: rtl/bit32_demux1to4_buf_pkg.sv
// Purpose : shared constants and helpers for the 1-to-4 word demultiplexer.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents:
//   NUM_CH / SEL_W       channel count and select width
//   DEF_WIDTH / DEF_CNT_W default data and counter widths
//   sel4()               4-to-1 single-bit selector used for per-channel status
package bit32_demux1to4_buf_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  // 4-to-1 selector: picks bit 'sel' of a per-channel status vector.
  function automatic logic sel4(input logic [NUM_CH-1:0] vec,
                                input logic [SEL_W-1:0]  sel);
    logic r;
    r = 1'b0;
    case (sel)
      2'd0:    r = vec[0];
      2'd1:    r = vec[1];
      2'd2:    r = vec[2];
      default: r = vec[3];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bit32_demux1to4_buf_slot.sv
// Purpose : one output channel; single-entry holding register, valid flag and wrapping load counter.
// Latency : a word loaded at edge N is visible on data_o/valid_o right after edge N.
// Backpr. : the slot can take a new word when empty or while being drained in the same cycle.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   load_i       write data_i into the holding register this edge (caller guarantees room)
//   data_i       word to hold
//   drain_i      consumer takes the held word this edge
//   data_o       holding-register contents (only changes on a load)
//   valid_o      holding register owns an unconsumed word
//   count_o      words loaded since reset, wraps to 0
module demux_slot
  import bit32_demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  // A load wins over a drain: with both in one cycle the old word leaves and the
  // new one takes its place, so valid stays high and full throughput is kept.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      count_d = count_q + CNT_W'(1);
    end else if (valid_q && drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/bit32_demux1to4_buf.sv
// Purpose : registered 1-to-4 demux; steers each accepted input word by in_sel into one of four held channels.
// Latency : one cycle from input acceptance to out_valid/out_data of the selected channel.
// Backpr. : in_ready drops only when the selected channel is full and its consumer is stalled.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   in_data/in_sel        word and destination channel (0..3)
//   in_valid/in_ready     input handshake; in_ready does not depend on in_valid
//   out_data0..3          per-channel holding registers
//   out_valid/out_ready   per-channel output handshake, bit k = channel k
//   count0..3             per-channel accepted-word counters (wrapping)
//   busy                  any channel holds a word
module bit32_demux1to4_buf
  import bit32_demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic [CNT_W-1:0]  count2,
  output logic [CNT_W-1:0]  count3,
  output logic              busy
);

  logic             accept;
  logic [WIDTH-1:0] slot_data [NUM_CH];
  logic [CNT_W-1:0] slot_cnt  [NUM_CH];

  // Ready only looks at the addressed channel, so a stalled channel blocks
  // nothing but the words aimed at it.
  assign in_ready = ~sel4(out_valid, in_sel) | sel4(out_ready, in_sel);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    logic load_k;
    assign load_k = accept & (in_sel == SEL_W'(k));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (load_k),
      .data_i  (in_data),
      .drain_i (out_ready[k]),
      .data_o  (slot_data[k]),
      .valid_o (out_valid[k]),
      .count_o (slot_cnt[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  assign count0 = slot_cnt[0];
  assign count1 = slot_cnt[1];
  assign count2 = slot_cnt[2];
  assign count3 = slot_cnt[3];

  assign busy = |out_valid;

endmodule

// File: tb/tb_bit32_demux1to4_buf.sv
module tb_bit32_demux1to4_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  count0, count1, count2, count3;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] dout [4];
  logic [7:0]  cnt  [4];
  assign dout[0] = out_data0;
  assign dout[1] = out_data1;
  assign dout[2] = out_data2;
  assign dout[3] = out_data3;
  assign cnt[0]  = count0;
  assign cnt[1]  = count1;
  assign cnt[2]  = count2;
  assign cnt[3]  = count3;

  always #5 clk = ~clk;

  bit32_demux1to4_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count0    (count0),
    .count1    (count1),
    .count2    (count2),
    .count3    (count3),
    .busy      (busy)
  );

  // Producer protocol: a stalled word must stay put until it is taken.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_sel;
  always @(posedge clk) begin
    if (reset) begin
      if (prev_stall)
        assert (in_valid && in_data == prev_data && in_sel == prev_sel)
          else $error("producer changed a stalled word");
      prev_stall <= in_valid & ~in_ready;
      prev_data  <= in_data;
      prev_sel   <= in_sel;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    reset     = 1'b0;
    step();
    reset     = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (dout[k] !== 32'h0) begin fails++; $display("FAIL reset_data%0d: got %h expected 0", k, dout[k]); end
      tests++; if (cnt[k] !== 8'h0) begin fails++; $display("FAIL reset_count%0d: got %0d expected 0", k, cnt[k]); end
    end
  endtask

  task automatic test_steering();
    logic [31:0] words [4];
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    do_reset();
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = words[i];
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL steer_rdy%0d: got %b expected 1", i, in_ready); end
      step();
      tests++; if (out_valid !== 4'(1 << i)) begin fails++; $display("FAIL steer_valid%0d: got %b expected %b", i, out_valid, 4'(1 << i)); end
      tests++; if (dout[i] !== words[i]) begin fails++; $display("FAIL steer_data%0d: got %h expected %h", i, dout[i], words[i]); end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL steer_drained: got %b/%b expected 0000/0", out_valid, busy); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (cnt[k] !== 8'd1) begin fails++; $display("FAIL steer_count%0d: got %0d expected 1", k, cnt[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 4'b1110;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hAAAA0001;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdyA: got %b expected 1", in_ready); end
    step();
    tests++; if (out_valid[0] !== 1'b1 || out_data0 !== 32'hAAAA0001) begin fails++; $display("FAIL bp_holdA: got %b/%h expected 1/aaaa0001", out_valid[0], out_data0); end
    in_data = 32'hBBBB0002;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_rdyB_full: got %b expected 0", in_ready); end
    step();
    tests++; if (out_data0 !== 32'hAAAA0001 || count0 !== 8'd1) begin fails++; $display("FAIL bp_stallA: got %h/%0d expected aaaa0001/1", out_data0, count0); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b expected 1", busy); end
    out_ready = 4'b1111;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdyB_drain: got %b expected 1", in_ready); end
    step();
    tests++; if (out_valid[0] !== 1'b1 || out_data0 !== 32'hBBBB0002 || count0 !== 8'd2) begin fails++; $display("FAIL bp_swap: got %b/%h/%0d expected 1/bbbb0002/2", out_valid[0], out_data0, count0); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 4'b0000 || out_data0 !== 32'hBBBB0002) begin fails++; $display("FAIL bp_empty: got %b/%h expected 0000/bbbb0002", out_valid, out_data0); end
  endtask

  task automatic test_independence();
    do_reset();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hC0FFEE01;
    step();
    for (int v = 5; v <= 8; v++) begin
      in_sel = 2'd3; in_data = 32'(v);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ind_rdy%0d: got %b expected 1", v, in_ready); end
      step();
      tests++; if (out_valid[3] !== 1'b1 || out_data3 !== 32'(v)) begin fails++; $display("FAIL ind_ch3_%0d: got %b/%h expected 1/%h", v, out_valid[3], out_data3, 32'(v)); end
      tests++; if (out_valid[1] !== 1'b1 || out_data1 !== 32'hC0FFEE01) begin fails++; $display("FAIL ind_ch1_%0d: got %b/%h expected 1/c0ffee01", v, out_valid[1], out_data1); end
    end
    in_valid = 1'b0; in_sel = 2'd1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ind_rdy_ch1: got %b expected 0", in_ready); end
    tests++; if (count3 !== 8'd4 || count1 !== 8'd1) begin fails++; $display("FAIL ind_counts: got %0d/%0d expected 4/1", count3, count1); end
    // An idle consumer asserting ready on an empty channel changes nothing.
    out_ready = 4'b1111;
    step(); step();
    tests++; if (out_valid !== 4'b0000 || count0 !== 8'd0 || count2 !== 8'd0) begin fails++; $display("FAIL ind_empty_rdy: got %b/%0d/%0d expected 0000/0/0", out_valid, count0, count2); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd2;
    for (int i = 1; i <= 257; i++) begin
      in_data = 32'(i);
      step();
      if (i == 255) begin
        tests++; if (count2 !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d expected 255", count2); end
      end
      if (i == 256) begin
        tests++; if (count2 !== 8'd0) begin fails++; $display("FAIL wrap_256: got %0d expected 0", count2); end
      end
    end
    in_valid = 1'b0;
    tests++; if (count2 !== 8'd1 || out_data2 !== 32'd257) begin fails++; $display("FAIL wrap_257: got %0d/%h expected 1/00000101", count2, out_data2); end
    tests++; if (count0 !== 8'd0 || count1 !== 8'd0 || count3 !== 8'd0) begin fails++; $display("FAIL wrap_others: got %0d/%0d/%0d expected 0/0/0", count0, count1, count3); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid[2] !== 1'b1 || out_data2 !== 32'hDEADBEEF) begin fails++; $display("FAIL mid_held: got %b/%h expected 1/deadbeef", out_valid[2], out_data2); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (out_valid !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b/%b expected 0000/0", out_valid, busy); end
    tests++; if (out_data2 !== 32'h0 || count2 !== 8'd0) begin fails++; $display("FAIL mid_rst_ch2: got %h/%0d expected 0/0", out_data2, count2); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_soak();
    logic [31:0] sbq [4][$];
    logic [7:0]  mcnt [4];
    logic        stall;
    logic        exp_rdy;
    logic [31:0] exp_w;
    do_reset();
    for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
    stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!stall) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      out_ready = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = (sbq[in_sel].size() == 0) || out_ready[in_sel];
      tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL soak_rdy c%0d: got %b expected %b", c, in_ready, exp_rdy); end
      for (int k = 0; k < 4; k++) begin
        tests++; if (out_valid[k] !== (sbq[k].size() != 0)) begin fails++; $display("FAIL soak_valid c%0d ch%0d: got %b expected %b", c, k, out_valid[k], sbq[k].size() != 0); end
        if (sbq[k].size() != 0 && out_ready[k]) begin
          exp_w = sbq[k].pop_front();
          tests++; if (dout[k] !== exp_w) begin fails++; $display("FAIL soak_data c%0d ch%0d: got %h expected %h", c, k, dout[k], exp_w); end
        end
      end
      if (in_valid && exp_rdy) begin
        sbq[in_sel].push_back(in_data);
        mcnt[in_sel] = mcnt[in_sel] + 8'd1;
      end
      stall = in_valid && !exp_rdy;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (cnt[k] !== mcnt[k]) begin fails++; $display("FAIL soak_count%0d: got %0d expected %0d", k, cnt[k], mcnt[k]); end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    #1;
    tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL por_valid: got %b expected 0000", out_valid); end
    test_reset();
    test_steering();
    test_backpressure();
    test_independence();
    test_wrap();
    test_reset_midstream();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
